// File: rtl/frame_acc16_pkg.sv
// Shared definitions for the frame_acc16 accumulator.
//   state_t  : FSM encoding (IDLE=0, ADD_LO=1, ADD_HI=2, OUT=3)
//   ACC_W    : accumulator / frame sum width
//   SAMPLE_W : input sample width, also the width of the shared adder slice
//   CNT_W    : sample counter width (holds 0..FRAME_LEN-1 for FRAME_LEN<=1024)
//   is_last  : true when the counter points at the final sample of a frame
package frame_acc16_pkg;

    localparam int ACC_W    = 16;
    localparam int SAMPLE_W = 8;
    localparam int CNT_W    = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD_LO = 2'd1,
        ADD_HI = 2'd2,
        OUT    = 2'd3
    } state_t;

    // The counter is compared before it is incremented, so it never needs to
    // hold FRAME_LEN itself and 10 bits cover frames of up to 1024 samples.
    function automatic logic is_last(input logic [CNT_W-1:0] cnt, input int frame_len);
        return (cnt == CNT_W'(frame_len - 1));
    endfunction

endpackage

// File: rtl/frame_acc16_add8_stage.sv
// add8_stage: combinational 8-bit adder with carry-in and carry-out.
// Ports:
//   i_a, i_b : 8-bit operands
//   i_cin    : carry-in
//   o_sum    : 8-bit sum
//   o_cout   : carry-out
module add8_stage
    import frame_acc16_pkg::*;
(
    input  logic [SAMPLE_W-1:0] i_a,
    input  logic [SAMPLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [SAMPLE_W-1:0] o_sum,
    output logic                o_cout
);

    logic [SAMPLE_W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SAMPLE_W{1'b0}}, i_cin};
    assign o_sum  = w_full[SAMPLE_W-1:0];
    assign o_cout = w_full[SAMPLE_W];

endmodule

// File: rtl/frame_acc16.sv
// frame_acc16: sums FRAME_LEN unsigned 8-bit samples into a 16-bit frame sum
// using a single shared 8-bit adder (low byte, then high byte plus carry), so
// one sample is accepted every three cycles.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   sample_in  : 8-bit sample, accepted when in_valid && in_ready
//   in_valid   : sample_in is valid
//   in_ready   : block accepts a sample this cycle (IDLE only)
//   sum_out    : accumulator value (frame sum while out_valid=1)
//   out_valid  : sum_out holds a completed frame
//   out_ready  : consumer accepts sum_out
//   ovf        : frame sum exceeded 16 bits (valid with out_valid)
// Configuration: define FRAME_ACC_SAT_EN to saturate the sum at 0xFFFF and
// report ovf; otherwise the sum wraps modulo 65536 and ovf is tied to 0.
module frame_acc16
    import frame_acc16_pkg::*;
#(
    parameter int FRAME_LEN = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ACC_W-1:0]    sum_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                ovf
);

    state_t              r_state;
    logic [SAMPLE_W-1:0] r_sample;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_count;
    logic                r_carry;
    logic                r_in_ready;
    logic                r_out_valid;
`ifdef FRAME_ACC_SAT_EN
    logic                r_ovf;
`endif

    logic [SAMPLE_W-1:0] w_add_a;
    logic [SAMPLE_W-1:0] w_add_b;
    logic                w_add_cin;
    logic [SAMPLE_W-1:0] w_add_sum;
    logic                w_add_cout;

    // Operand mux for the shared adder: low byte + sample, then high byte + carry.
    always_comb begin
        w_add_a   = 8'd0;
        w_add_b   = 8'd0;
        w_add_cin = 1'b0;
        case (r_state)
            ADD_LO: begin
                w_add_a = r_acc[7:0];
                w_add_b = r_sample;
            end
            ADD_HI: begin
                w_add_a   = r_acc[15:8];
                w_add_cin = r_carry;
            end
            default: begin
                w_add_a   = 8'd0;
                w_add_b   = 8'd0;
                w_add_cin = 1'b0;
            end
        endcase
    end

    add8_stage u_add8 (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // Frame FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sample    <= 8'd0;
            r_acc       <= 16'd0;
            r_count     <= 10'd0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef FRAME_ACC_SAT_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    // in_ready comes up one cycle after reset release
                    if (r_in_ready && in_valid) begin
                        r_sample   <= sample_in;
                        r_in_ready <= 1'b0;
                        r_state    <= ADD_LO;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ADD_LO: begin
`ifdef FRAME_ACC_SAT_EN
                    // once saturated, the sum is frozen at 0xFFFF
                    if (!r_ovf) begin
                        r_acc[7:0] <= w_add_sum;
                    end else begin
                        r_acc[7:0] <= r_acc[7:0];
                    end
`else
                    r_acc[7:0] <= w_add_sum;
`endif
                    r_carry <= w_add_cout;
                    r_state <= ADD_HI;
                end
                ADD_HI: begin
`ifdef FRAME_ACC_SAT_EN
                    if (r_ovf || w_add_cout) begin
                        r_acc <= 16'hFFFF;
                        r_ovf <= 1'b1;
                    end else begin
                        r_acc[15:8] <= w_add_sum;
                    end
`else
                    // carry-out dropped: the sum wraps modulo 65536
                    r_acc[15:8] <= w_add_sum;
`endif
                    r_carry <= 1'b0;
                    r_count <= r_count + CNT_W'(1);
                    if (is_last(r_count, FRAME_LEN)) begin
                        r_state     <= OUT;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_acc       <= 16'd0;
                        r_count     <= 10'd0;
`ifdef FRAME_ACC_SAT_EN
                        r_ovf       <= 1'b0;
`endif
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign sum_out   = r_acc;
    assign out_valid = r_out_valid;
`ifdef FRAME_ACC_SAT_EN
    assign ovf       = r_ovf;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_frame_acc16.sv
// Testbench for frame_acc16: four instances (FRAME_LEN = 4, 2, 300, 1) share
// clock and reset; a queue of expected frame results is filled as frames are
// driven and drained by a monitor whenever a frame is handed over.
module tb_frame_acc16;

    logic        clk;
    logic        rst;
    logic [7:0]  sample    [4];
    logic [15:0] sum_out   [4];
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [3:0]  ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          k;
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [31:0] s;        // four samples, first sample in the top byte
        int          exp_sum;
    } vec_t;

    vec_t tbl[5];

    frame_acc16 #(.FRAME_LEN(4)) u_len4 (
        .clk(clk), .rst(rst), .sample_in(sample[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .sum_out(sum_out[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .ovf(ovf[0]));

    frame_acc16 #(.FRAME_LEN(2)) u_len2 (
        .clk(clk), .rst(rst), .sample_in(sample[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .sum_out(sum_out[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .ovf(ovf[1]));

    frame_acc16 #(.FRAME_LEN(300)) u_len300 (
        .clk(clk), .rst(rst), .sample_in(sample[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .sum_out(sum_out[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .ovf(ovf[2]));

    frame_acc16 #(.FRAME_LEN(1)) u_len1 (
        .clk(clk), .rst(rst), .sample_in(sample[3]), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .sum_out(sum_out[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .ovf(ovf[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input int sum, input logic o);
        exp_t e;
        e.k   = k;
        e.sum = sum[15:0];
        e.ovf = o;
        sb_q.push_back(e);
    endtask

    // Wait for in_ready, present one sample, and check in_ready stays low
    // during the two add cycles.
    task automatic send(input int k, input logic [7:0] v);
        int n;
        n = 0;
        while (in_ready[k] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            chk("ready_timeout", int'(in_ready[k]), 1);
        end else begin
            sample[k]   = v;
            in_valid[k] = 1'b1;
            tick();
            chk("rdy_add_lo", int'(in_ready[k]), 0);
            tick();
            chk("rdy_add_hi", int'(in_ready[k]), 0);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    // Scoreboard and handshake-exclusivity monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            chk("rdy_valid_excl", int'(in_ready[k] & out_valid[k]), 0);
            if (!rst && out_valid[k] && out_ready[k]) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", int'(out_valid[k]), 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_instance", k, e.k);
                    chk("sb_sum", int'(sum_out[k]), int'(e.sum));
                    chk("sb_ovf", int'(ovf[k]), int'(e.ovf));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;

        tbl[0] = '{32'h0A141E28, 100};
        tbl[1] = '{32'hFFFFFFFF, 1020};
        tbl[2] = '{32'h00000000, 0};
        tbl[3] = '{32'h01020304, 10};
        tbl[4] = '{32'h808001FF, 512};

        rst       = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) sample[k] = 8'd0;

        // reset state
        #3;
        chk("rst_sum", int'(sum_out[0]), 0);
        chk("rst_out_valid", int'(out_valid[0]), 0);
        chk("rst_in_ready", int'(in_ready[0]), 0);
        chk("rst_ovf", int'(ovf[0]), 0);
        tick();
        tick();
        rst = 1'b0;
        chk("rdy_before_edge", int'(in_ready[0]), 0);
        tick();
        chk("rdy_after_release", int'(in_ready[0]), 1);

        // 10+20+30+40 with in_valid held high: one-cycle out_valid pulse
        push(0, 100, 1'b0);
        send(0, 8'd10);
        send(0, 8'd20);
        send(0, 8'd30);
        send(0, 8'd40);
        in_valid[0] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid[0]) pulses++;
        end
        chk("out_valid_pulse_len", pulses, 1);
        chk("drain_basic", sb_q.size(), 0);

        // table of four-sample frames
        for (int i = 0; i < 5; i++) begin
            push(0, tbl[i].exp_sum, 1'b0);
            for (int j = 0; j < 4; j++) send(0, tbl[i].s[31-8*j -: 8]);
            in_valid[0] = 1'b0;
            wait_drain();
        end

        // low-byte carry into the high byte
        push(1, 16'h0100, 1'b0);
        send(1, 8'hFF);
        send(1, 8'h01);
        in_valid[1] = 1'b0;
        wait_drain();
        push(1, 16'h0100, 1'b0);
        send(1, 8'h80);
        send(1, 8'h80);
        in_valid[1] = 1'b0;
        wait_drain();

        // back-pressure: output held while out_ready is low
        out_ready[0] = 1'b0;
        push(0, 10, 1'b0);
        send(0, 8'd1);
        send(0, 8'd2);
        send(0, 8'd3);
        send(0, 8'd4);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", int'(out_valid[0]), 1);
            chk("stall_sum", int'(sum_out[0]), 10);
            chk("stall_in_ready", int'(in_ready[0]), 0);
            tick();
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        chk("stall_drained", int'(out_valid[0]), 0);
        chk("stall_sum_cleared", int'(sum_out[0]), 0);
        chk("stall_sb_empty", sb_q.size(), 0);

        // asynchronous reset in the second sample's ADD_HI cycle
        send(0, 8'd7);
        while (in_ready[0] !== 1'b1) tick();
        sample[0]   = 8'd9;
        in_valid[0] = 1'b1;
        tick();
        tick();
        in_valid[0] = 1'b0;
        chk("pre_reset_sum", int'(sum_out[0]), 16);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sum", int'(sum_out[0]), 0);
        chk("async_rst_in_ready", int'(in_ready[0]), 0);
        chk("async_rst_out_valid", int'(out_valid[0]), 0);
        tick();
        tick();
        rst = 1'b0;
        push(0, 20, 1'b0);
        for (int j = 0; j < 4; j++) send(0, 8'd5);
        in_valid[0] = 1'b0;
        wait_drain();

        // single-sample frames
        push(3, 77, 1'b0);
        send(3, 8'd77);
        in_valid[3] = 1'b0;
        wait_drain();
        push(3, 200, 1'b0);
        send(3, 8'd200);
        in_valid[3] = 1'b0;
        wait_drain();

        // 300 x 255 = 76500 exceeds 16 bits
`ifdef FRAME_ACC_SAT_EN
        push(2, 16'hFFFF, 1'b1);
`else
        push(2, 10964, 1'b0);
`endif
        for (int j = 0; j < 300; j++) send(2, 8'hFF);
        in_valid[2] = 1'b0;
        wait_drain();

        // the instance that overflowed starts its next frame clean
        push(2, 300, 1'b0);
        for (int j = 0; j < 300; j++) send(2, 8'd1);
        in_valid[2] = 1'b0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
